// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change path.
// Stock-tracking types are consumed only when CHANGE_STOCK_EN is defined.
package vend_pkg;

  localparam int AMT_W_DEF = 7;
  localparam int NUM_DENOM = 4;

  localparam int COIN_1  = 1;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_50 = 50;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  typedef enum logic [1:0] {D_1 = 2'd0, D_5 = 2'd1, D_10 = 2'd2, D_50 = 2'd3} denom_e;

  function automatic denom_e denom_idx(input int unsigned val);
    denom_e idx;
    case (val)
      COIN_50: idx = D_50;
      COIN_10: idx = D_10;
      COIN_5:  idx = D_5;
      default: idx = D_1;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/change_denom_pick.sv
// Greedy coin selector: largest available denomination not exceeding rem_i.
// With CHANGE_STOCK_EN, avail_i masks out denominations whose hopper is empty.
module change_denom_pick
  import vend_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic [AMT_W-1:0]     rem_i,
`ifdef CHANGE_STOCK_EN
  input  logic [NUM_DENOM-1:0] avail_i,
`endif
  output logic [AMT_W-1:0]     coin_o,
  output logic                 none_o
);

  logic [NUM_DENOM-1:0] ok;

  always_comb begin
`ifdef CHANGE_STOCK_EN
    ok = avail_i;
`else
    ok = '1;
`endif
    coin_o = '0;
    if      (rem_i >= AMT_W'(COIN_50) && ok[D_50]) coin_o = AMT_W'(COIN_50);
    else if (rem_i >= AMT_W'(COIN_10) && ok[D_10]) coin_o = AMT_W'(COIN_10);
    else if (rem_i >= AMT_W'(COIN_5)  && ok[D_5])  coin_o = AMT_W'(COIN_5);
    else if (rem_i >= AMT_W'(COIN_1)  && ok[D_1])  coin_o = AMT_W'(COIN_1);
    none_o = (coin_o == '0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Breaks a change amount into 50/10/5/1 coins and hands them out one per handshake.
// Optional CHANGE_STOCK_EN adds per-denomination hopper stock, refill and short reporting.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF
`ifdef CHANGE_STOCK_EN
  , parameter int STOCK_INIT = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chg_req,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             coin_valid,
  output logic [AMT_W-1:0] coin_val,
  input  logic             coin_ready,
  output logic             busy,
  output logic             done
`ifdef CHANGE_STOCK_EN
  , input  logic             refill
  , output logic             short
  , output logic [AMT_W-1:0] short_amt
`endif
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d, val_q, val_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [AMT_W-1:0] rem_sub, pick_in, pick_coin;
  logic             hs, pick_none;

  assign hs      = valid_q & coin_ready;
  assign rem_sub = rem_q - val_q;
  // One selector serves both the first coin (from chg_amt) and the lookahead coin after a handshake.
  assign pick_in = (state_q == IDLE) ? chg_amt : rem_sub;

`ifdef CHANGE_STOCK_EN
  logic [NUM_DENOM-1:0][7:0] stock_q, stock_d;
  logic [NUM_DENOM-1:0]      avail;
  logic                      short_q, short_d;
  logic [AMT_W-1:0]          samt_q, samt_d;

  // Lookahead must see the post-handshake stock so an emptied hopper is skipped immediately.
  always_comb begin
    stock_d = stock_q;
    if (state_q == IDLE && refill) stock_d = {NUM_DENOM{8'(STOCK_INIT)}};
    else if (hs) stock_d[denom_idx(32'(val_q))] = stock_q[denom_idx(32'(val_q))] - 8'd1;
    for (int i = 0; i < NUM_DENOM; i++) avail[i] = |stock_d[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stock_q <= {NUM_DENOM{8'(STOCK_INIT)}};
      short_q <= 1'b0;
      samt_q  <= '0;
    end else begin
      stock_q <= stock_d;
      short_q <= short_d;
      samt_q  <= samt_d;
    end
  end

  assign short     = short_q;
  assign short_amt = samt_q;
`endif

  change_denom_pick #(.AMT_W(AMT_W)) u_pick (
    .rem_i   (pick_in),
`ifdef CHANGE_STOCK_EN
    .avail_i (avail),
`endif
    .coin_o  (pick_coin),
    .none_o  (pick_none)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef CHANGE_STOCK_EN
    short_d = short_q;
    samt_d  = samt_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (chg_req) begin
          busy_d = 1'b1;
          rem_d  = chg_amt;
          // pick_none covers both a zero amount and an amount nothing in stock can serve.
          if (pick_none) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef CHANGE_STOCK_EN
            short_d = (chg_amt != '0);
            samt_d  = chg_amt;
`endif
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
            val_d   = pick_coin;
`ifdef CHANGE_STOCK_EN
            short_d = 1'b0;
            samt_d  = '0;
`endif
          end
        end
      end
      ISSUE: begin
        if (hs) begin
          rem_d = rem_sub;
          if (pick_none) begin
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            val_d   = '0;
`ifdef CHANGE_STOCK_EN
            short_d = (rem_sub != '0);
            samt_d  = rem_sub;
`endif
          end else begin
            val_d = pick_coin;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rem_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign coin_valid = valid_q;
  assign coin_val   = val_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy coin-list reference model.
// Build with CHANGE_STOCK_EN to exercise stock, refill and short reporting.
module tb_change_dispenser;

  localparam int AMT_W = 7;
`ifdef CHANGE_STOCK_EN
  localparam int SI = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             chg_req = 1'b0;
  logic [AMT_W-1:0] chg_amt = '0;
  logic             coin_ready = 1'b0;
  logic             coin_valid, busy, done;
  logic [AMT_W-1:0] coin_val;
`ifdef CHANGE_STOCK_EN
  logic             refill = 1'b0;
  logic             short;
  logic [AMT_W-1:0] short_amt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_short;
  int stock[4];  // order: 50, 10, 5, 1

  always #5 clk = ~clk;

  change_dispenser #(
    .AMT_W(AMT_W)
`ifdef CHANGE_STOCK_EN
    , .STOCK_INIT(SI)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chg_req    (chg_req),
    .chg_amt    (chg_amt),
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .coin_ready (coin_ready),
    .busy       (busy),
    .done       (done)
`ifdef CHANGE_STOCK_EN
    , .refill    (refill)
    , .short     (short)
    , .short_amt (short_amt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reload();
    for (int i = 0; i < 4; i++) begin
`ifdef CHANGE_STOCK_EN
      stock[i] = SI;
`else
      stock[i] = 1000;
`endif
    end
  endtask

  // Reference: pay out largest stocked coin that fits until nothing fits.
  task automatic model(input int amt);
    int d[4] = '{50, 10, 5, 1};
    int rem;
    bit found;
    rem = amt;
    exp_q.delete();
    exp_short = 0;
    while (rem > 0) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && d[i] <= rem && stock[i] > 0) begin
          found = 1'b1;
          exp_q.push_back(d[i]);
          rem -= d[i];
`ifdef CHANGE_STOCK_EN
          stock[i]--;
`endif
        end
      end
      if (!found) begin
        exp_short = rem;
        rem = 0;
      end
    end
  endtask

  // mode: 0 = ready always high, 1 = ready toggles starting low, 2 = random ready
  task automatic txn(input int amt, input int mode, input bit inject);
    int  n, cyc;
    bit  fin, tog, r;
    n = 0; cyc = 0; fin = 1'b0; tog = 1'b0;
    model(amt);
    chg_req    = 1'b1;
    chg_amt    = AMT_W'(amt);
    coin_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chg_req = 1'b0;
    while (!fin && cyc < 300) begin
      if (done) begin
        chk("coin_count", n, exp_q.size());
        chk("done_valid", {31'd0, coin_valid}, 0);
        chk("done_busy", {31'd0, busy}, 1);
        if (mode == 0) chk("latency", cyc, exp_q.size());
`ifdef CHANGE_STOCK_EN
        chk("short", {31'd0, short}, (exp_short != 0) ? 1 : 0);
        chk("short_amt", {25'd0, short_amt}, exp_short);
`endif
        fin = 1'b1;
        coin_ready = 1'b0;
      end else begin
        chk("valid", {31'd0, coin_valid}, 1);
        chk("busy", {31'd0, busy}, 1);
        if (n < exp_q.size()) chk("coin_val", {25'd0, coin_val}, exp_q[n]);
        else chk("extra_coin", n, exp_q.size());
        case (mode)
          0:       r = 1'b1;
          1:       begin r = tog; tog = ~tog; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        coin_ready = r;
        if (coin_valid && r) n++;
        if (inject && $urandom_range(0, 2) == 0) begin
          chg_req = 1'b1;
          chg_amt = AMT_W'($urandom_range(1, 127));
        end else begin
          chg_req = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    chg_req = 1'b0;
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_valid", {31'd0, coin_valid}, 0);
  endtask

`ifdef CHANGE_STOCK_EN
  task automatic do_refill();
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    reload();
  endtask
`endif

  initial begin
    reload();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, coin_valid}, 0);
    chk("rst_val", {25'd0, coin_val}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    reset = 1'b0;
    coin_ready = 1'b1;  // ready with no coin presented must be ignored
    @(negedge clk);
    chk("idle_ready_valid", {31'd0, coin_valid}, 0);

    txn(26, 0, 1'b0);
    txn(77, 1, 1'b0);
    txn(0, 0, 1'b0);
    txn(26, 0, 1'b1);

    // Reset mid-dispense after two coins have been handed over.
    model(26);
    chg_req = 1'b1; chg_amt = AMT_W'(26); coin_ready = 1'b1;
    @(negedge clk);
    chg_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, coin_valid}, 0);
    chk("midrst_val", {25'd0, coin_val}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    reset = 1'b0;
    coin_ready = 1'b0;
    reload();
    txn(5, 0, 1'b0);

`ifdef CHANGE_STOCK_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reload();
    txn(26, 0, 1'b0);
    do_refill();
    txn(10, 0, 1'b0);
`endif

    for (int k = 0; k < 25; k++) begin
`ifdef CHANGE_STOCK_EN
      if ($urandom_range(0, 1) == 1) do_refill();
`endif
      txn($urandom_range(0, 127), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
